// File: rtl/exemplo_func4_pkg.sv
// Shared definitions for the exemplo_func4 Boolean function unit: table width,
// default table and the {a,b,c,d} index ordering.
package exemplo_func4_pkg;

  localparam int TT_W  = 16;
  localparam int IDX_W = 4;

  // Default table encodes (a & ~c) | (b & c) | d
  localparam logic [TT_W-1:0] TT_DEFAULT = 16'hFBEA;

  // Table index: a is the MSB, d the LSB
  function automatic logic [IDX_W-1:0] tt_index(input logic a, input logic b,
                                                input logic c, input logic d);
    return {a, b, c, d};
  endfunction

endpackage

// File: rtl/exemplo_func4_tt_lut.sv
// Combinational 16:1 selection of one truth-table bit by the 4-bit function index.
module exemplo_tt_lut
  import exemplo_func4_pkg::*;
(
  input  logic [TT_W-1:0]  tt,
  input  logic [IDX_W-1:0] idx,
  output logic             f
);

  assign f = tt[idx];

endmodule

// File: rtl/exemplo_func4.sv
// Registered 4-input Boolean function unit with run-time reprogrammable table and
// saturating toggle counter. Define EXEMPLO_EDGE_EN to add s_rise/s_fall pulse outputs.
module exemplo_func4
  import exemplo_func4_pkg::*;
#(
  parameter logic [TT_W-1:0] TT_INIT = TT_DEFAULT,
  parameter int              CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  input  logic             cfg_we,
  input  logic [TT_W-1:0]  cfg_tt,
  output logic             s,
  output logic [TT_W-1:0]  tt,
  output logic [CNT_W-1:0] toggle_cnt
`ifdef EXEMPLO_EDGE_EN
  ,
  output logic             s_rise,
  output logic             s_fall
`endif
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [TT_W-1:0]  tt_r;
  logic             s_r;
  logic [CNT_W-1:0] cnt_r;
  logic [IDX_W-1:0] idx_s;
  logic             lut_s;
  logic             toggle_s;
  logic [CNT_W-1:0] cnt_next_s;

  assign idx_s = tt_index(a, b, c, d);

  // Lookup always reads the registered table, so a write only affects the following edge
  exemplo_tt_lut u_lut (
    .tt  (tt_r),
    .idx (idx_s),
    .f   (lut_s)
  );

  assign toggle_s = lut_s ^ s_r;

  // Next toggle count: increment on a change of s, hold at all-ones
  always_comb begin
    cnt_next_s = cnt_r;
    if (toggle_s && (cnt_r != CNT_MAX)) begin
      cnt_next_s = cnt_r + CNT_ONE;
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Table, output and counter registers; rst wins over cfg_we
  always_ff @(posedge clk) begin
    if (rst) begin
      tt_r  <= TT_INIT;
      s_r   <= 1'b0;
      cnt_r <= CNT_ZERO;
    end else begin
      if (cfg_we) begin
        tt_r <= cfg_tt;
      end
      s_r   <= lut_s;
      cnt_r <= cnt_next_s;
    end
  end

  assign s          = s_r;
  assign tt         = tt_r;
  assign toggle_cnt = cnt_r;

`ifdef EXEMPLO_EDGE_EN
  logic s_rise_r;
  logic s_fall_r;

  // Edge pulses are registered alongside s so they coincide with the new value
  always_ff @(posedge clk) begin
    if (rst) begin
      s_rise_r <= 1'b0;
      s_fall_r <= 1'b0;
    end else begin
      s_rise_r <= lut_s & ~s_r;
      s_fall_r <= ~lut_s & s_r;
    end
  end

  assign s_rise = s_rise_r;
  assign s_fall = s_fall_r;
`endif

endmodule

// File: tb/tb_exemplo_func4.sv
// Directed self-checking bench for exemplo_func4 (edge outputs checked when
// EXEMPLO_EDGE_EN is defined).
module tb_exemplo_func4;

  logic        clk;
  logic        rst;
  logic        a, b, c, d;
  logic        cfg_we;
  logic [15:0] cfg_tt;
  logic        s;
  logic [15:0] tt;
  logic [7:0]  toggle_cnt;
`ifdef EXEMPLO_EDGE_EN
  logic        s_rise;
  logic        s_fall;
`endif

  int n_cmp = 0;
  int n_err = 0;

  exemplo_func4 #(.TT_INIT(16'hFBEA), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .b          (b),
    .c          (c),
    .d          (d),
    .cfg_we     (cfg_we),
    .cfg_tt     (cfg_tt),
    .s          (s),
    .tt         (tt),
    .toggle_cnt (toggle_cnt)
`ifdef EXEMPLO_EDGE_EN
    ,
    .s_rise     (s_rise),
    .s_fall     (s_fall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then settle so outputs are sampled away from the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [3:0] v);
    {a, b, c, d} = v;
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_we = 1'b0; cfg_tt = 16'h0000; set_in(4'b1111);
    step();
    rst = 1'b0;
    n_cmp++; if (s !== 1'b0) begin n_err++; $display("FAIL reset_s: got %b want 0", s); end
    n_cmp++; if (tt !== 16'hFBEA) begin n_err++; $display("FAIL reset_tt: got %h want fbea", tt); end
    n_cmp++; if (toggle_cnt !== 8'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", toggle_cnt); end
  endtask

  task automatic test_default_table();
    logic [3:0] vec [4];
    logic       exp [4];
    vec = '{4'b0000, 4'b1000, 4'b1010, 4'b0110};
    exp = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      set_in(vec[i]);
      step();
      n_cmp++;
      if (s !== exp[i]) begin
        n_err++; $display("FAIL default_vec%0d: got %b want %b", i, s, exp[i]);
      end
    end
    n_cmp++; if (toggle_cnt !== 8'd3) begin n_err++; $display("FAIL default_cnt: got %0d want 3", toggle_cnt); end
    // xxx1 -> 1, s already 1 so no toggle
    set_in(4'b0001);
    step();
    n_cmp++; if (s !== 1'b1) begin n_err++; $display("FAIL default_0001: got %b want 1", s); end
    n_cmp++; if (toggle_cnt !== 8'd3) begin n_err++; $display("FAIL default_cnt_hold: got %0d want 3", toggle_cnt); end
  endtask

  task automatic test_cfg_write();
    set_in(4'b1111); cfg_we = 1'b1; cfg_tt = 16'h8000;
    step();
    cfg_we = 1'b0;
    n_cmp++; if (s !== 1'b1) begin n_err++; $display("FAIL cfg_old_table: got %b want 1", s); end
    n_cmp++; if (tt !== 16'h8000) begin n_err++; $display("FAIL cfg_tt_readback: got %h want 8000", tt); end
    step();
    n_cmp++; if (s !== 1'b1) begin n_err++; $display("FAIL cfg_new_1111: got %b want 1", s); end
    set_in(4'b0111);
    step();
    n_cmp++; if (s !== 1'b0) begin n_err++; $display("FAIL cfg_new_0111: got %b want 0", s); end
    n_cmp++; if (toggle_cnt !== 8'd4) begin n_err++; $display("FAIL cfg_cnt: got %0d want 4", toggle_cnt); end
  endtask

  task automatic test_back_to_back();
    set_in(4'b0000);
    cfg_we = 1'b1; cfg_tt = 16'h0001;
    step();
    n_cmp++; if (s !== 1'b0) begin n_err++; $display("FAIL b2b_edge1: got %b want 0", s); end
    cfg_tt = 16'h0002;
    step();
    cfg_we = 1'b0;
    n_cmp++; if (s !== 1'b1) begin n_err++; $display("FAIL b2b_edge2: got %b want 1", s); end
    step();
    n_cmp++; if (s !== 1'b0) begin n_err++; $display("FAIL b2b_edge3: got %b want 0", s); end
    n_cmp++; if (tt !== 16'h0002) begin n_err++; $display("FAIL b2b_tt: got %h want 0002", tt); end
  endtask

  task automatic test_saturation();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      set_in((i % 2 == 0) ? 4'b1000 : 4'b0000);
      step();
      if (i == 99) begin
        n_cmp++; if (toggle_cnt !== 8'd100) begin n_err++; $display("FAIL sat_mid: got %0d want 100", toggle_cnt); end
      end
    end
    n_cmp++; if (toggle_cnt !== 8'd255) begin n_err++; $display("FAIL sat_end: got %0d want 255", toggle_cnt); end
    n_cmp++; if (s !== 1'b0) begin n_err++; $display("FAIL sat_s: got %b want 0", s); end
  endtask

  task automatic test_reset_override();
    set_in(4'b1000);
    step();
    n_cmp++; if (s !== 1'b1) begin n_err++; $display("FAIL ovr_pre_s: got %b want 1", s); end
    rst = 1'b1; cfg_we = 1'b1; cfg_tt = 16'h0000;
    step();
    rst = 1'b0; cfg_we = 1'b0;
    n_cmp++; if (s !== 1'b0) begin n_err++; $display("FAIL ovr_s: got %b want 0", s); end
    n_cmp++; if (tt !== 16'hFBEA) begin n_err++; $display("FAIL ovr_tt: got %h want fbea", tt); end
    n_cmp++; if (toggle_cnt !== 8'd0) begin n_err++; $display("FAIL ovr_cnt: got %0d want 0", toggle_cnt); end
    step();
    n_cmp++; if (s !== 1'b1) begin n_err++; $display("FAIL ovr_post_s: got %b want 1", s); end
    n_cmp++; if (toggle_cnt !== 8'd1) begin n_err++; $display("FAIL ovr_post_cnt: got %0d want 1", toggle_cnt); end
  endtask

`ifdef EXEMPLO_EDGE_EN
  task automatic test_edges();
    logic [3:0] vec [5];
    logic       er  [5];
    logic       ef  [5];
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if ({s_rise, s_fall} !== 2'b00) begin n_err++; $display("FAIL edge_reset: got %b want 00", {s_rise, s_fall}); end
    vec = '{4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0000};
    er  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    ef  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      set_in(vec[i]);
      step();
      n_cmp++;
      if ({s_rise, s_fall} !== {er[i], ef[i]}) begin
        n_err++; $display("FAIL edge_step%0d: got %b want %b", i, {s_rise, s_fall}, {er[i], ef[i]});
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b0; cfg_we = 1'b0; cfg_tt = 16'h0000; set_in(4'b0000);
    test_reset();
    test_default_table();
    test_cfg_write();
    test_back_to_back();
    test_saturation();
    test_reset_override();
`ifdef EXEMPLO_EDGE_EN
    test_edges();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
